// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle: register IDs and control bits in, stall/flush/forward controls out.
// master = pipeline datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  logic [REG_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/control unit for the 5-stage RISC-V pipe: forwarding, load-use stall, branch flush, memory-wait freeze.
// Optional perf counters (stall_cnt/flush_cnt) are built only when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 8
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hif
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic {IDLE, MEM_WAIT} state_e;

  state_e          state_q, state_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            mem_err_q, mem_err_d;

  logic       lw_stall, mem_stall;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  assign lw_stall  = hif.LoadE && (hif.RdE != 5'd0) &&
                     ((hif.RdE == hif.Rs1D) || (hif.RdE == hif.Rs2D));
  assign mem_stall = ((state_q == IDLE) && hif.MemReqM && !hif.MemReadyM) ||
                     (state_q == MEM_WAIT);

  // Memory-wait FSM: tcnt counts MEM_WAIT cycles; abort when it reaches MEM_TIMEOUT.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    mem_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (hif.MemReqM && !hif.MemReadyM) begin
          state_d = MEM_WAIT;
          tcnt_d  = TO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hif.MemReadyM) begin
          state_d = IDLE;
          tcnt_d  = '0;
        end else if (tcnt_q == TO_W'(MEM_TIMEOUT)) begin
          state_d   = IDLE;
          tcnt_d    = '0;
          mem_err_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Control outputs: memory freeze beats branch flush beats load-use stall; all held low in reset.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    if (rst) begin
      if (hif.RegWriteM && (hif.RdM != 5'd0) && (hif.RdM == hif.Rs1E))      fwd_a = 2'b10;
      else if (hif.RegWriteW && (hif.RdW != 5'd0) && (hif.RdW == hif.Rs1E)) fwd_a = 2'b01;
      if (hif.RegWriteM && (hif.RdM != 5'd0) && (hif.RdM == hif.Rs2E))      fwd_b = 2'b10;
      else if (hif.RegWriteW && (hif.RdW != 5'd0) && (hif.RdW == hif.Rs2E)) fwd_b = 2'b01;

      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (hif.PCSrcE) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign hif.StallF    = stall_f;
  assign hif.StallD    = stall_d;
  assign hif.StallE    = stall_e;
  assign hif.StallM    = stall_m;
  assign hif.FlushD    = flush_d;
  assign hif.FlushE    = flush_e;
  assign hif.FlushW    = flush_w;
  assign hif.ForwardAE = fwd_a;
  assign hif.ForwardBE = fwd_b;
  assign hif.mem_err   = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Free-running wrap-around event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_f);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_e);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hif.stall_cnt = stall_cnt_q;
  assign hif.flush_cnt = flush_cnt_q;
`else
  assign hif.stall_cnt = CNT_W'(0);
  assign hif.flush_cnt = CNT_W'(0);
`endif

endmodule
